// File: rtl/in_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package  : in_unit_pkg
// Brief    : Shared types and sizing constants for the input unit and its
//            neighbours on the CDB.
// Revision : 1.0 - initial release
// ============================================================================
package in_unit_pkg;

    localparam int ROB_WIDTH     = 4;
    localparam int IN_N_ENTRY    = 4;
    localparam int IN_FIFO_DEPTH = 16;

    // One result broadcast on the common data bus
    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } cdb_t;

    // IN results are the received byte zero-extended to a full word
    function automatic logic [31:0] zext_byte(input logic [7:0] b);
        return {24'h000000, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/in_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : req_if
// Brief     : Minimal valid/ready handshake. The master drives valid, the
//             slave answers with ready; a transfer happens when both are high.
// Revision  : 1.0 - initial release
// ============================================================================
interface req_if;
    logic valid;
    logic ready;

    modport master (output valid, input ready);
    modport slave  (input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/in_unit_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : byte_fifo
// Brief    : Circular byte FIFO with a random-access peek at an offset from
//            the read pointer. Pushes while full are dropped; pops while empty
//            are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    input  logic [AW-1:0] peek_off,
    output logic [7:0]    dout,
    output logic [AW:0]   fcount,
    output logic          not_full
);

    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   fcount_q, fcount_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic          w_write;
    logic          w_pop;
    logic [AW-1:0] w_peek_idx;

    assign not_full   = (fcount_q < c_full_count);
    assign w_write    = push && not_full;
    assign w_pop      = pop && (fcount_q != '0);
    assign w_peek_idx = rd_ptr_q + peek_off;
    assign dout       = mem_q[w_peek_idx];
    assign fcount     = fcount_q;

    // Next-state for pointers, occupancy and storage; pointers wrap mod DEPTH
    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(w_pop);
        wr_ptr_d = wr_ptr_q + AW'(w_write);
        fcount_d = fcount_q + (AW+1)'(w_write) - (AW+1)'(w_pop);
        mem_d    = mem_q;
        if (w_write) begin
            mem_d[wr_ptr_q] = din;
        end
    end

    // Control state registers, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fcount_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fcount_q <= fcount_d;
        end
    end

    // Byte storage; contents are only meaningful under fcount, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/in_unit.sv
`default_nettype none
// ============================================================================
// Module   : in_unit
// Brief    : Input unit. Buffers UART bytes, tracks in-flight IN instructions
//            by ROB tag, broadcasts each IN's byte on the CDB as soon as one is
//            available, and consumes the byte only when the IN commits so that
//            squashed INs never lose input.
// Revision : 1.0 - initial release
// ============================================================================
module in_unit
    import in_unit_pkg::*;
#(
    parameter int N_ENTRY    = IN_N_ENTRY,
    parameter int FIFO_DEPTH = IN_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    req_if.slave                 issue_req,
    input  logic [ROB_WIDTH-1:0] issue_tag,
    req_if.slave                 commit_req,
    input  logic                 flush,
    req_if.master                cdb_req,
    output cdb_t                 cdb_out,
    input  logic                 receiver_valid,
    input  logic [7:0]           receiver_out,
    output logic                 receiver_ready
);

    localparam int c_tag_aw  = $clog2(N_ENTRY);
    localparam int c_fifo_aw = $clog2(FIFO_DEPTH);
    localparam logic [c_tag_aw:0] c_n_entry_cnt = (c_tag_aw+1)'(N_ENTRY);

    logic [ROB_WIDTH-1:0] tag_q [N_ENTRY];
    logic [ROB_WIDTH-1:0] tag_d [N_ENTRY];
    logic [c_tag_aw-1:0]  head_q, head_d;
    logic [c_tag_aw:0]    count_q, count_d;
    logic [c_tag_aw:0]    n_done_q, n_done_d;

    logic                 w_issue;
    logic                 w_commit;
    logic                 w_grant;
    logic                 w_cdb_valid;
    logic                 w_not_full;
    logic [7:0]           w_byte;
    logic [c_fifo_aw:0]   fcount;
    logic [c_fifo_aw:0]   w_n_done_ext;
    logic [c_fifo_aw-1:0] w_peek_off;
    logic [c_tag_aw-1:0]  w_rd_idx;
    logic [c_tag_aw-1:0]  w_wr_idx;

    // Byte buffer; entries beyond the committed head are peeked at n_done
    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_byte_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (receiver_valid),
        .pop      (w_commit),
        .din      (receiver_out),
        .peek_off (w_peek_off),
        .dout     (w_byte),
        .fcount   (fcount),
        .not_full (w_not_full)
    );

    assign w_n_done_ext = (c_fifo_aw+1)'(n_done_q);
    assign w_peek_off   = c_fifo_aw'(n_done_q);
    assign w_rd_idx     = head_q + n_done_q[c_tag_aw-1:0];
    assign w_wr_idx     = head_q + count_q[c_tag_aw-1:0];

    // Handshakes; an issue may enter a full queue when a commit frees a slot
    assign receiver_ready   = w_not_full;
    assign commit_req.ready = (n_done_q != '0);
    assign w_commit         = commit_req.valid && commit_req.ready;
    assign issue_req.ready  = (count_q < c_n_entry_cnt) || w_commit;
    assign w_issue          = issue_req.valid && issue_req.ready;

    // Oldest un-broadcast IN goes out once a byte exists for it
    assign w_cdb_valid   = (n_done_q < count_q) && (w_n_done_ext < fcount);
    assign cdb_req.valid = w_cdb_valid;
    assign w_grant       = w_cdb_valid && cdb_req.ready;
    assign cdb_out.valid = w_cdb_valid;
    assign cdb_out.tag   = tag_q[w_rd_idx];
    assign cdb_out.data  = zext_byte(w_byte);

    // Tag queue and broadcast-progress bookkeeping; flush drops all INs
    always_comb begin
        tag_d    = tag_q;
        head_d   = head_q + c_tag_aw'(w_commit);
        count_d  = count_q;
        n_done_d = n_done_q;
        if (flush) begin
            count_d  = '0;
            n_done_d = '0;
        end else begin
            count_d  = count_q + (c_tag_aw+1)'(w_issue) - (c_tag_aw+1)'(w_commit);
            n_done_d = n_done_q + (c_tag_aw+1)'(w_grant) - (c_tag_aw+1)'(w_commit);
            if (w_issue) begin
                tag_d[w_wr_idx] = issue_tag;
            end
        end
    end

    // Queue state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            count_q  <= '0;
            n_done_q <= '0;
            for (int i = 0; i < N_ENTRY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            count_q  <= count_d;
            n_done_q <= n_done_d;
            tag_q    <= tag_d;
        end
    end

    // A commit is only meaningful for an IN whose result was broadcast
    a_commit_has_done: assert property (@(posedge clk) disable iff (!rst_n)
        commit_req.valid |-> (n_done_q != '0));

endmodule
`default_nettype wire

// File: tb/tb_in_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_in_unit
// Brief    : Self-checking bench for in_unit with a broadcast scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_in_unit;
    import in_unit_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [ROB_WIDTH-1:0] issue_tag = '0;
    logic                 flush = 1'b0;
    logic                 receiver_valid = 1'b0;
    logic [7:0]           receiver_out = '0;
    logic                 receiver_ready;
    cdb_t                 cdb_out;

    req_if issue_if ();
    req_if commit_if ();
    req_if cdb_if ();

    always #5 clk = ~clk;

    in_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_req      (issue_if),
        .issue_tag      (issue_tag),
        .commit_req     (commit_if),
        .flush          (flush),
        .cdb_req        (cdb_if),
        .cdb_out        (cdb_out),
        .receiver_valid (receiver_valid),
        .receiver_out   (receiver_out),
        .receiver_ready (receiver_ready)
    );

    typedef struct {
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Scoreboard: every granted broadcast must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && cdb_if.valid && cdb_if.ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cdb_unexpected: got tag=%0d data=%h, required no broadcast",
                         cdb_out.tag, cdb_out.data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cdb_out.tag !== e.tag || cdb_out.data !== e.data) begin
                    errors++;
                    $display("FAIL cdb_bcast: got tag=%0d data=%h, required tag=%0d data=%h",
                             cdb_out.tag, cdb_out.data, e.tag, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bcast(input logic [ROB_WIDTH-1:0] t, input logic [7:0] b);
        exp_t e;
        e.tag  = t;
        e.data = {24'h000000, b};
        exp_q.push_back(e);
    endtask

    task automatic push_byte(input logic [7:0] b);
        receiver_valid = 1'b1;
        receiver_out   = b;
        tick();
        receiver_valid = 1'b0;
    endtask

    task automatic issue(input logic [ROB_WIDTH-1:0] t);
        issue_if.valid = 1'b1;
        issue_tag      = t;
        tick();
        issue_if.valid = 1'b0;
    endtask

    task automatic grant_one;
        cdb_if.ready = 1'b1;
        tick();
        cdb_if.ready = 1'b0;
    endtask

    task automatic commit_one;
        commit_if.valid = 1'b1;
        tick();
        commit_if.valid = 1'b0;
    endtask

    task automatic do_reset;
        issue_if.valid  = 1'b0;
        commit_if.valid = 1'b0;
        cdb_if.ready    = 1'b0;
        flush           = 1'b0;
        receiver_valid  = 1'b0;
        rst_n           = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({cdb_if.valid, issue_if.ready, commit_if.ready, receiver_ready} !== 4'b0101) begin
            errors++;
            $display("FAIL reset_outputs: got cdbv/issr/comr/rxr=%b, required 0101",
                     {cdb_if.valid, issue_if.ready, commit_if.ready, receiver_ready});
        end
        checks++;
        if (dut.count_q !== 3'd0 || dut.n_done_q !== 3'd0 || dut.fcount !== 5'd0) begin
            errors++;
            $display("FAIL reset_counts: got count=%0d n_done=%0d fcount=%0d, required 0/0/0",
                     dut.count_q, dut.n_done_q, dut.fcount);
        end
    endtask

    task automatic test_single;
        do_reset();
        expect_bcast(4'd5, 8'h41);
        issue(4'd5);
        checks++;
        if (cdb_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL single_no_byte: got cdb valid=%b, required 0", cdb_if.valid);
        end
        push_byte(8'h41);
        checks++;
        if (cdb_if.valid !== 1'b1 || cdb_out.tag !== 4'd5 || cdb_out.data !== 32'h41) begin
            errors++;
            $display("FAIL single_latency: got v=%b tag=%0d data=%h, required v=1 tag=5 data=00000041",
                     cdb_if.valid, cdb_out.tag, cdb_out.data);
        end
        grant_one();
        checks++;
        if (commit_if.ready !== 1'b1 || cdb_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL single_granted: got commit ready=%b cdb valid=%b, required 1/0",
                     commit_if.ready, cdb_if.valid);
        end
        commit_one();
        checks++;
        if (dut.fcount !== 5'd0 || dut.count_q !== 3'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_commit: got fcount=%0d count=%0d pending=%0d, required 0/0/0",
                     dut.fcount, dut.count_q, exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [3];
        bytes[0] = 8'h10;
        bytes[1] = 8'h20;
        bytes[2] = 8'h30;
        do_reset();
        for (int i = 0; i < 3; i++) push_byte(bytes[i]);
        cdb_if.ready   = 1'b1;
        issue_if.valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_bcast(4'(i + 1), bytes[i]);
            issue_tag = 4'(i + 1);
            tick();
            checks++;
            if (cdb_if.valid !== 1'b1 || cdb_out.tag !== 4'(i + 1) ||
                cdb_out.data !== {24'h0, bytes[i]}) begin
                errors++;
                $display("FAIL b2b_slot%0d: got v=%b tag=%0d data=%h, required v=1 tag=%0d data=%h",
                         i, cdb_if.valid, cdb_out.tag, cdb_out.data, i + 1, {24'h0, bytes[i]});
            end
        end
        issue_if.valid = 1'b0;
        tick();
        cdb_if.ready = 1'b0;
        checks++;
        if (dut.n_done_q !== 3'd3 || cdb_if.valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_done: got n_done=%0d cdbv=%b pending=%0d, required 3/0/0",
                     dut.n_done_q, cdb_if.valid, exp_q.size());
        end
        commit_if.valid = 1'b1;
        tick();
        tick();
        tick();
        commit_if.valid = 1'b0;
        checks++;
        if (dut.fcount !== 5'd0 || dut.count_q !== 3'd0 || commit_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_commit: got fcount=%0d count=%0d commit ready=%b, required 0/0/0",
                     dut.fcount, dut.count_q, commit_if.ready);
        end
    endtask

    task automatic test_flush;
        do_reset();
        issue(4'd1);
        issue(4'd2);
        expect_bcast(4'd1, 8'hAA);
        expect_bcast(4'd2, 8'hBB);
        cdb_if.ready = 1'b1;
        push_byte(8'hAA);
        push_byte(8'hBB);
        tick();
        cdb_if.ready = 1'b0;
        checks++;
        if (dut.n_done_q !== 3'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL flush_pre: got n_done=%0d pending=%0d, required 2/0",
                     dut.n_done_q, exp_q.size());
        end
        flush          = 1'b1;
        issue_if.valid = 1'b1;
        issue_tag      = 4'd9;
        tick();
        flush          = 1'b0;
        issue_if.valid = 1'b0;
        checks++;
        if (dut.count_q !== 3'd0 || dut.n_done_q !== 3'd0 || dut.fcount !== 5'd2 ||
            cdb_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: got count=%0d n_done=%0d fcount=%0d cdbv=%b, required 0/0/2/0",
                     dut.count_q, dut.n_done_q, dut.fcount, cdb_if.valid);
        end
        expect_bcast(4'd7, 8'hAA);
        issue(4'd7);
        checks++;
        if (cdb_if.valid !== 1'b1 || cdb_out.tag !== 4'd7 || cdb_out.data !== 32'hAA) begin
            errors++;
            $display("FAIL flush_rebcast: got v=%b tag=%0d data=%h, required v=1 tag=7 data=000000aa",
                     cdb_if.valid, cdb_out.tag, cdb_out.data);
        end
        grant_one();
        commit_one();
        checks++;
        if (dut.fcount !== 5'd1 || dut.count_q !== 3'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL flush_commit: got fcount=%0d count=%0d pending=%0d, required 1/0/0",
                     dut.fcount, dut.count_q, exp_q.size());
        end
    endtask

    task automatic test_full_issue;
        do_reset();
        for (int i = 0; i < 4; i++) issue(4'(i));
        checks++;
        if (issue_if.ready !== 1'b0 || dut.count_q !== 3'd4) begin
            errors++;
            $display("FAIL full_ready: got issue ready=%b count=%0d, required 0/4",
                     issue_if.ready, dut.count_q);
        end
        expect_bcast(4'd0, 8'h55);
        push_byte(8'h55);
        grant_one();
        commit_if.valid = 1'b1;
        issue_if.valid  = 1'b1;
        issue_tag       = 4'd9;
        #1;
        checks++;
        if (issue_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL full_bypass: got issue ready=%b, required 1", issue_if.ready);
        end
        tick();
        commit_if.valid = 1'b0;
        issue_if.valid  = 1'b0;
        checks++;
        if (dut.count_q !== 3'd4 || dut.n_done_q !== 3'd0 || dut.fcount !== 5'd0) begin
            errors++;
            $display("FAIL full_swap: got count=%0d n_done=%0d fcount=%0d, required 4/0/0",
                     dut.count_q, dut.n_done_q, dut.fcount);
        end
        expect_bcast(4'd1, 8'h66);
        expect_bcast(4'd2, 8'h67);
        expect_bcast(4'd3, 8'h68);
        expect_bcast(4'd9, 8'h69);
        for (int i = 0; i < 4; i++) push_byte(8'(8'h66 + i));
        cdb_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        cdb_if.ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || dut.n_done_q !== 3'd4) begin
            errors++;
            $display("FAIL full_order: got pending=%0d n_done=%0d, required 0/4",
                     exp_q.size(), dut.n_done_q);
        end
    endtask

    task automatic test_fifo_full;
        do_reset();
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
        checks++;
        if (receiver_ready !== 1'b0 || dut.fcount !== 5'd16) begin
            errors++;
            $display("FAIL fifo_full: got rx ready=%b fcount=%0d, required 0/16",
                     receiver_ready, dut.fcount);
        end
        push_byte(8'hEE);
        checks++;
        if (dut.fcount !== 5'd16) begin
            errors++;
            $display("FAIL fifo_overflow: got fcount=%0d, required 16", dut.fcount);
        end
        expect_bcast(4'd4, 8'h80);
        issue(4'd4);
        grant_one();
        commit_one();
        checks++;
        if (receiver_ready !== 1'b1 || dut.fcount !== 5'd15) begin
            errors++;
            $display("FAIL fifo_drain: got rx ready=%b fcount=%0d, required 1/15",
                     receiver_ready, dut.fcount);
        end
        expect_bcast(4'd5, 8'h81);
        issue(4'd5);
        grant_one();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL fifo_second: got pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        issue(4'd2);
        push_byte(8'h33);
        checks++;
        if (cdb_if.valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got cdb valid=%b, required 1", cdb_if.valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cdb_if.valid, issue_if.ready, commit_if.ready, receiver_ready} !== 4'b0101) begin
            errors++;
            $display("FAIL rstmid_outputs: got cdbv/issr/comr/rxr=%b, required 0101",
                     {cdb_if.valid, issue_if.ready, commit_if.ready, receiver_ready});
        end
        checks++;
        if (dut.count_q !== 3'd0 || dut.n_done_q !== 3'd0 || dut.fcount !== 5'd0) begin
            errors++;
            $display("FAIL rstmid_counts: got count=%0d n_done=%0d fcount=%0d, required 0/0/0",
                     dut.count_q, dut.n_done_q, dut.fcount);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        issue_if.valid  = 1'b0;
        commit_if.valid = 1'b0;
        cdb_if.ready    = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_full_issue();
        test_fifo_full();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
